pc_sequencer: RTL

// - Control-flow sequencer for program_counter: drives start, branch/condition strobes,

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_link_stack.sv | 39 +++
 rtl/pc_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared op classes, run states and fault codes for the pc sequencer
package pc_seq_pkg;
    typedef enum logic [3:0] {
        OP_SEQ  = 4'd0,
        OP_BIZR = 4'd1,
        OP_BNZR = 4'd2,
        OP_JIZR = 4'd3,
        OP_JNZR = 4'd4,
        OP_CALL = 4'd5,
        OP_RET  = 4'd6,
        OP_LJ0  = 4'd8,
        OP_LJ1  = 4'd9,
        OP_LJ2  = 4'd10,
        OP_LJ3  = 4'd11,
        OP_HALT = 4'd15
    } seq_op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} seq_state_e;
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
endpackage

// File: rtl/pc_sequencer_link_stack.sv
// link_stack: return-address stack with a registered top-of-stack output
module link_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          din,
    output logic [AW-1:0]          top,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   full,
    output logic                   empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = IW + 1;
    logic [AW-1:0] mem [DEPTH];
    logic [SW-1:0] spm2;
    assign full  = sp == SW'(DEPTH);
    assign empty = sp == '0;
    assign spm2  = sp - SW'(2);
    // top is kept equal to mem[sp-1] so the caller sees it with no read latency
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            sp  <= '0;
            top <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[sp[IW-1:0]] <= din;
            sp  <= sp + SW'(1);
            top <= din;
        end else if (pop && !empty) begin
            sp  <= sp - SW'(1);
            top <= sp >= SW'(2) ? mem[spm2[IW-1:0]] : '0;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: run-state FSM and control-flow strobe decode for program_counter
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          go,
    input  logic          op_valid,
    input  seq_op_e       op_class,
    input  logic          zero_flag,
    input  logic [AW-1:0] npc,
    output logic          start,
    output logic          branch,
    output logic          bizr,
    output logic          bnzr,
    output logic          jizr,
    output logic          jnzr,
    output logic          jump2sub,
    output logic          retFsub,
    output logic          lj0,
    output logic          lj1,
    output logic          lj2,
    output logic          lj3,
    output logic [AW-1:0] rl,
    output logic          done,
    output logic          fault,
    output logic [1:0]    fault_code
);
    seq_state_e state;
    logic act, ovf, unf, full, empty;
    logic [$clog2(DEPTH):0] sp;
    assign start = state != S_RUN;
    assign done  = state == S_DONE;
    assign fault = state == S_FAULT;
    always_comb begin
        act      = state == S_RUN && op_valid;
        bizr     = act && op_class == OP_BIZR && zero_flag;
        bnzr     = act && op_class == OP_BNZR && !zero_flag;
        jizr     = act && op_class == OP_JIZR && zero_flag;
        jnzr     = act && op_class == OP_JNZR && !zero_flag;
        branch   = bizr || bnzr || jizr || jnzr;
        jump2sub = act && op_class == OP_CALL && !full;
        retFsub  = act && op_class == OP_RET && !empty;
        ovf      = act && op_class == OP_CALL && full;
        unf      = act && op_class == OP_RET && empty;
        lj0      = act && op_class == OP_LJ0;
        lj1      = act && op_class == OP_LJ1;
        lj2      = act && op_class == OP_LJ2;
        lj3      = act && op_class == OP_LJ3;
    end
    link_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
        .clk(clk), .reset_n(reset_n), .clr(go && state != S_RUN),
        .push(jump2sub), .pop(retFsub), .din(npc),
        .top(rl), .sp(sp), .full(full), .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            fault_code <= FC_NONE;
        end else if (state == S_RUN) begin
            if (ovf) begin
                state      <= S_FAULT;
                fault_code <= FC_OVF;
            end else if (unf) begin
                state      <= S_FAULT;
                fault_code <= FC_UNF;
            end else if (act && op_class == OP_HALT) begin
                state <= S_DONE;
            end
        end else if (go) begin
            state      <= S_RUN;
            fault_code <= FC_NONE;
        end
    end
endmodule
